// File: rtl/dmem_hs.sv
// dmem_hs -- byte-addressable data memory with a valid/ready request port
// and a fixed-latency, one-cycle response pulse. One request is in flight
// at a time; a pipelined core stalls on req_ready.
//
// Parameters:
//   ADDR_W  byte-address bits decoded (capacity 2**ADDR_W bytes, >= 3)
//   RD_LAT  load latency in cycles from accept to response, 1..4
//
// Ports:
//   clk, rst                   clock (rising edge), async active-high reset
//   req_valid / req_ready      request handshake
//   req_we, req_size,          store/load, 00 byte 01 half 10 word 11 illegal,
//   req_unsigned               zero-extend byte/half loads
//   req_addr, req_wdata        byte address, store data (low bytes used)
//   rsp_valid, rsp_rdata,      one-cycle response pulse, load result
//   rsp_err                    (0 for stores/errors), error flag
//
// Optional feature macro: DMEM_STRICT_ALIGN_EN -- when defined, misaligned
// half/word accesses are errors; otherwise they are performed bytewise with
// addresses wrapping modulo 2**ADDR_W.
//
// Storage is four byte-wide banks selected by address bits [1:0], so any
// access (aligned or not) touches each bank at most once per cycle.
module dmem_hs #(
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);
  localparam logic [1:0] CNT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  cnt_reg, cnt_next;

  // Attributes of the accepted request, held until its response.
  logic        ld_reg, err_reg, uns_reg;
  logic [1:0]  size_reg, off_reg;

  logic        accept;
  logic        size_bad, range_bad, misalign, req_err;
  logic [31:0] lane_q;      // bank read registers, lane gi = bank gi
  logic [63:0] lane_dbl;
  logic [31:0] raw, ext;

  assign accept    = req_valid && req_ready;
  assign size_bad  = (req_size == 2'b11);
  assign range_bad = ((req_addr >> ADDR_W) != 32'd0);

`ifdef DMEM_STRICT_ALIGN_EN
  assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                    ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign req_err = size_bad || range_bad || misalign;

  // Per-bank storage. Byte k of the access lives at addr+k, which lands in
  // bank (addr+k)[1:0]; inverting that, bank gi carries byte k = gi - addr[1:0].
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_bank
      logic [7:0]        mem [0:DEPTH-1];
      logic [7:0]        rd_q;
      logic [1:0]        k;
      logic [ADDR_W-1:0] ba;
      logic              in_access, wr_en;

      assign k  = 2'(gi) - req_addr[1:0];
      assign ba = req_addr[ADDR_W-1:0] + ADDR_W'(k);
      assign in_access = (req_size == 2'b10) ||
                         ((req_size == 2'b01) && (k < 2'd2)) ||
                         ((req_size == 2'b00) && (k == 2'd0));
      assign wr_en = accept && req_we && !req_err && in_access;

      // Load bytes are captured at the accept edge, so later stores cannot
      // disturb a response that is already in flight.
      always_ff @(posedge clk) begin
        if (wr_en)
          mem[ba[ADDR_W-1:2]] <= req_wdata[{k, 3'b000} +: 8];
        if (accept)
          rd_q <= mem[ba[ADDR_W-1:2]];
      end

      assign lane_q[gi*8 +: 8] = rd_q;
    end
  endgenerate

  // Rotate lanes back into access order: byte k comes from bank off+k.
  assign lane_dbl = {lane_q, lane_q};
  assign raw      = lane_dbl[{off_reg, 3'b000} +: 32];

  always_comb begin
    ext = raw;
    case (size_reg)
      2'b00:   ext = uns_reg ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2'b01:   ext = uns_reg ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 2'd0;
      ld_reg    <= 1'b0;
      err_reg   <= 1'b0;
      uns_reg   <= 1'b0;
      size_reg  <= 2'b00;
      off_reg   <= 2'b00;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        ld_reg   <= !req_we;
        err_reg  <= req_err;
        uns_reg  <= req_unsigned;
        size_reg <= req_size;
        off_reg  <= req_addr[1:0];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE, S_RESP: begin
        if (accept) begin
          // Errored loads keep load timing, so only req_we picks the path.
          if (!req_we && (RD_LAT > 1)) begin
            state_next = S_WAIT;
            cnt_next   = CNT_INIT;
          end else begin
            state_next = S_RESP;
          end
        end else begin
          state_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_reg == 2'd0)
          state_next = S_RESP;
        else
          cnt_next = cnt_reg - 2'd1;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign req_ready = (state_reg != S_WAIT);
  assign rsp_valid = (state_reg == S_RESP);
  assign rsp_err   = (state_reg == S_RESP) && err_reg;
  assign rsp_rdata = ((state_reg == S_RESP) && ld_reg && !err_reg) ? ext : 32'd0;

endmodule

// File: tb/tb_dmem_hs.sv
// tb_dmem_hs -- randomized scoreboard bench for dmem_hs. The driver issues
// requests, computes each expected response from a flat byte-array model of
// the memory and queues it with its due cycle; an independent monitor pops
// and compares whenever the DUT pulses rsp_valid, and checks req_ready.
module tb_dmem_hs;

  localparam int ADDR_W = 16;
  localparam int RD_LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  int total  = 0;
  int passed = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t sbq[$];
  byte unsigned ref_mem [65536];

  dmem_hs #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_rsp_err"},   {31'd0, rsp_err},   32'd0);
  endtask

  // Reference behaviour: flat byte memory, little-endian, RV32I extension.
  function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rd, output logic err);
    int nb;
    logic [31:0] v;
    nb  = 1 << size;
    err = (size == 2'b11) || (addr[31:16] != 16'd0);
`ifdef DMEM_STRICT_ALIGN_EN
    if (size != 2'b11 && (addr % nb) != 0) err = 1'b1;
`endif
    rd = 32'd0;
    if (err) return;
    if (we) begin
      for (int k = 0; k < nb; k++)
        ref_mem[(addr + k) % 65536] = wdata[8*k +: 8];
    end else begin
      v = 32'd0;
      for (int k = 0; k < nb; k++)
        v[8*k +: 8] = ref_mem[(addr + k) % 65536];
      if (!uns && nb == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (!uns && nb == 2 && v[15]) v = v | 32'hFFFF_0000;
      rd = v;
    end
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata);
    int   guard;
    exp_t e;
    guard        = 0;
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    while (req_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (req_ready !== 1'b1) begin
      total++;
      $display("FAIL ready_timeout: req_ready stayed %b, expected 1 within 20 cycles", req_ready);
      req_valid = 1'b0;
      return;
    end
    model(we, size, uns, addr, wdata, e.rdata, e.err);
    e.due = cyc + 1 + (we ? 0 : RD_LAT - 1);
    sbq.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Monitor: sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    logic rdy_exp;
    #1;
    rdy_exp = (sbq.size() == 0) || (sbq[0].due <= cyc);
    chk("req_ready", {31'd0, req_ready}, {31'd0, rdy_exp});
    if (sbq.size() != 0 && sbq[0].due < cyc) begin
      total++;
      $display("FAIL rsp_missing: no response by cycle %0d, expected at cycle %0d", cyc, sbq[0].due);
      void'(sbq.pop_front());
    end
    if (rsp_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        total++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 at cycle %0d, expected no response", cyc);
      end else begin
        e = sbq.pop_front();
        $display("rsp cyc=%0d rdata=%h err=%b (exp rdata=%h err=%b)", cyc, rsp_rdata, rsp_err, e.rdata, e.err);
        chk("rsp_cycle", 32'(cyc), 32'(e.due));
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err",   {31'd0, rsp_err}, {31'd0, e.err});
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    int          r;

    #1;
    chk_reset("por");
    @(negedge clk);
    rst = 1'b0;

    // Write known zeros to every region later touched by loads.
    for (int i = 0; i < 72; i += 4) send(1'b1, 2'b10, 1'b0, 32'(i), 32'd0);
    for (int i = 'hFFF0; i <= 'hFFFC; i += 4) send(1'b1, 2'b10, 1'b0, 32'(i), 32'd0);

    // Word round trip and extension.
    send(1'b1, 2'b10, 1'b0, 32'h10, 32'h8765_4321);
    send(1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
    send(1'b0, 2'b00, 1'b0, 32'h13, 32'd0);
    send(1'b0, 2'b00, 1'b1, 32'h13, 32'd0);
    send(1'b0, 2'b01, 1'b0, 32'h12, 32'd0);
    send(1'b0, 2'b01, 1'b1, 32'h12, 32'd0);

    // Range and size errors; memory must be untouched.
    send(1'b1, 2'b10, 1'b0, 32'h0001_0000, 32'hDEAD_BEEF);
    send(1'b0, 2'b10, 1'b0, 32'h0, 32'd0);
    send(1'b0, 2'b11, 1'b0, 32'h10, 32'd0);
    send(1'b1, 2'b11, 1'b0, 32'h14, 32'h1234_5678);
    send(1'b0, 2'b10, 1'b0, 32'h14, 32'd0);

    // Misaligned store and wrap at the top of the address space.
    send(1'b1, 2'b10, 1'b0, 32'h21, 32'hAABB_CCDD);
    for (int i = 'h21; i <= 'h24; i++) send(1'b0, 2'b00, 1'b1, 32'(i), 32'd0);
    send(1'b1, 2'b10, 1'b0, 32'hFFFF, 32'h1122_3344);
    send(1'b0, 2'b10, 1'b0, 32'h0, 32'd0);
    send(1'b0, 2'b10, 1'b0, 32'hFFFF, 32'd0);

    // Asynchronous reset in the middle of a load: response must vanish.
    send(1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    sbq.delete();
    #1;
    chk_reset("async");
    @(negedge clk);
    rst = 1'b0;
    send(1'b0, 2'b10, 1'b0, 32'h10, 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 15);
      if (r == 0)      a = {16'($urandom_range(1, 65535)), 16'($urandom)};
      else if (r == 1) a = 32'hFFF0 + 32'($urandom_range(0, 15));
      else             a = 32'($urandom_range(0, 63));
      r  = $urandom_range(0, 15);
      sz = (r == 15) ? 2'b11 : 2'(r % 3);
      send(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    repeat (RD_LAT + 4) @(negedge clk);
    total++;
    if (sbq.size() == 0) passed++;
    else $display("FAIL drain: got %0d responses outstanding, expected 0", sbq.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dmem_hs.md
# dmem_hs

Parametrised byte-addressable data memory with a valid/ready request port and a registered, fixed-latency response port. It replaces the combinational-read data memory on the CPU load/store path. It adds:
- configurable depth and read latency;
- explicit error reporting for illegal, out-of-range and misaligned accesses;
- a one-outstanding-request state machine, so a pipelined core can stall on `req_ready`.

Byte order is little-endian; loads sign- or zero-extend per RV32I.

## Interface
Parameters:
- `ADDR_W`, 16: byte-address bits actually decoded; capacity is 2**`ADDR_W` bytes.
- `RD_LAT`, 1: read latency in cycles from accept to response; legal range 1..4.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept; transfer occurs when `req_valid && req_ready` at a rising edge.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`  in  1  load zero-extends (LBU/LHU); ignored for stores and words.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, taken from the low bytes.
- `rsp_valid`  out  1  one-cycle response pulse; there is no backpressure.
- `rsp_rdata`  out  32  load result; 0 for stores and errors.
- `rsp_err`  out  1  qualified by `rsp_valid`.

## Operation
State machine:
- **IDLE**: `req_ready`=1. On accept, go to WAIT if load and `RD_LAT`>1, else go to RESP.
- **WAIT**: `req_ready`=0. A down-counter is loaded with `RD_LAT`-2 and decremented each cycle; at 0, go to RESP.
- **RESP**: `rsp_valid`=1 and `req_ready`=1. On accept, branch as in IDLE; otherwise go to IDLE.

Access rules:
- **Store**: memory bytes are written at the accept edge; the response carries `rsp_rdata`=0.
- **Load**: bytes are sampled at the accept edge and extended into a held register; the result is presented at response. A store accepted on the RESP edge of a load does not alter that load's data.
- **Error conditions**: `req_size`=11, or `req_addr[31:ADDR_W]`≠0. On error:
  - no memory change;
  - `rsp_err`=1, `rsp_rdata`=0;
  - normal latency (store timing for stores, `RD_LAT` for loads).
- **Alignment**: handled as configured, see Configuration.
- **Extension**: byte/half loads sign-extend from bit 7/15 unless `req_unsigned`=1.
- **Memory contents**: not reset; the simulation initial value is all zero.

## Timing
- Accept at edge T:
  - stores: `rsp_valid` is high for the cycle after edge T+1;
  - loads: `rsp_valid` is high for the cycle after edge T+`RD_LAT`.
- Throughput:
  - stores, and loads with `RD_LAT`=1: one request per cycle, back-to-back through RESP;
  - otherwise: one load per `RD_LAT` cycles.
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, state IDLE, counter 0.
- Reset asserted mid-load: the response is dropped. A store already accepted remains committed.
- `req_*` inputs are don't-care when there is no accept.

## Configuration
- `DMEM_STRICT_ALIGN_EN` defined:
  - half with `addr[0]`=1, or word with `addr[1:0]`≠0, is an error;
  - errors follow the error rules: no write, `rsp_err`=1.
- `DMEM_STRICT_ALIGN_EN` undefined:
  - misaligned accesses are performed bytewise at addr, addr+1, …;
  - byte addresses wrap modulo 2**`ADDR_W`;
  - `rsp_err`=0.
- Range and size checks apply in both builds.

## Test plan
- **Reset/idle**: assert `rst` mid-cycle → all outputs go to their reset values immediately, without waiting for a clock edge.
- **Word round trip**, `RD_LAT`=1: store word 0x8765_4321 at 0x10, then back-to-back load word 0x10 →
  - store ack, then load response on the next cycle with `rsp_rdata`=0x8765_4321;
  - `req_ready` never drops.
- **Extension**: load byte 0x13 signed → 0xFFFF_FF87; LBU → 0x0000_0087; load half 0x12 signed → 0xFFFF_8765; LHU → 0x0000_8765.
- **Latency**, `RD_LAT`=3: load at edge T →
  - `req_ready`=0 through WAIT;
  - `rsp_valid` high only in the cycle after T+3.
- **Errors**, `ADDR_W`=16:
  - store to 0x0001_0000 → `rsp_err`=1 and memory unchanged;
  - `req_size`=11 → `rsp_err`=1, `rsp_rdata`=0.
- **Alignment**: store word 0xAABB_CCDD at 0x21 →
  - strict build: `rsp_err`=1;
  - relaxed build: bytes 0x21..0x24 = DD,CC,BB,AA, and a word store at 0xFFFF wraps its upper bytes to 0x0000..0x0002.
- **Reset mid-load**, `RD_LAT`=4: assert `rst` at T+2 → no response is produced; the next request is accepted normally.
